// File: rtl/hir_ctrl_pkg.sv
// Shared types and defaults for the HIR loop-control blocks.
package hir_ctrl_pkg;

   typedef enum logic {IDLE, RUN} loop_state_t;

   localparam int DEFAULT_IDX_W = 32;

endpackage : hir_ctrl_pkg

// File: rtl/hir_delay_line.sv
// 1-bit tapped shift register: tap 0 is a combinational copy of din,
// tap k is din delayed by k cycles. Used to give loop bodies time offsets.
module hir_delay_line #(
   parameter int DELAY = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   output logic [DELAY-1:0] dout
);

   assign dout[0] = din;

   for (genvar k = 1; k < DELAY; k++) begin : g_stage
      logic stage_d;
      logic stage_q;

      assign stage_d = dout[k-1];

      // One delay stage per tap.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) stage_q <= 1'b0;
         else        stage_q <= stage_d;
      end

      assign dout[k] = stage_q;
   end

endmodule : hir_delay_line

// File: rtl/hir_for_loop_ctrl.sv
// Sequencer for one counted loop level: captures lb/ub/step on tstart,
// pulses tloop once per iteration (advanced by tloop_in), then tfinish.
// Optional delay taps on tloop/tfinish are built when HIR_LOOP_CTRL_DELAY_EN
// is defined.
module hir_for_loop_ctrl
   import hir_ctrl_pkg::*;
#(
   parameter int IDX_W  = DEFAULT_IDX_W,
   parameter int STEP_W = 8,
   parameter int DELAY  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tstart,
   input  logic [IDX_W-1:0]  lb,
   input  logic [IDX_W-1:0]  ub,
   input  logic [STEP_W-1:0] step,
   input  logic              tloop_in,
   output logic [IDX_W-1:0]  idx,
   output logic              tloop,
   output logic              tfinish,
   output logic              busy,
   output logic              err
`ifdef HIR_LOOP_CTRL_DELAY_EN
   ,
   output logic [DELAY-1:0]  tloop_dly,
   output logic [DELAY-1:0]  tfinish_dly
`endif
);

   loop_state_t       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  ub_q, ub_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              tloop_q, tloop_d;
   logic              tfinish_q, tfinish_d;
   logic              err_q, err_d;

   // One extra bit so an index that overflows IDX_W ends the loop instead of wrapping.
   logic [IDX_W:0]    nxt;
   logic              nxt_in_range;
   logic              start_go;
   logic              start_empty;

   assign nxt          = {1'b0, idx_q} + {{(IDX_W+1-STEP_W){1'b0}}, step_q};
   assign nxt_in_range = nxt < {1'b0, ub_q};
   assign start_empty  = ub <= lb;
   assign start_go     = !start_empty && (step != '0);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         ub_q      <= '0;
         step_q    <= '0;
         tloop_q   <= 1'b0;
         tfinish_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q   <= state_d;
         idx_q     <= idx_d;
         ub_q      <= ub_d;
         step_q    <= step_d;
         tloop_q   <= tloop_d;
         tfinish_q <= tfinish_d;
         err_q     <= err_d;
      end
   end

   // Next state: tstart always (re)loads; a yield past the bound returns to IDLE.
   always_comb begin
      // NOTE: default first so no path through the case leaves a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (tstart && start_go) state_d = RUN;
         end
         RUN: begin
            if (tstart)                         state_d = start_go ? RUN : IDLE;
            else if (tloop_in && !nxt_in_range) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath: loop registers and the pulses issued on the next edge.
   always_comb begin
      idx_d     = idx_q;
      ub_d      = ub_q;
      step_d    = step_q;
      tloop_d   = 1'b0;
      tfinish_d = 1'b0;
      err_d     = 1'b0;
      if (tstart) begin
         idx_d     = lb;
         ub_d      = ub;
         step_d    = step;
         tloop_d   = start_go;
         tfinish_d = !start_go;
         // Zero step with work to do is refused; a restart aborts the running loop.
         err_d     = (!start_empty && (step == '0)) || (state_q == RUN);
      end else if (tloop_in) begin
         if (state_q == RUN) begin
            if (nxt_in_range) begin
               idx_d   = nxt[IDX_W-1:0];
               tloop_d = 1'b1;
            end else begin
               tfinish_d = 1'b1;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign idx     = idx_q;
   assign tloop   = tloop_q;
   assign tfinish = tfinish_q;
   assign err     = err_q;
   assign busy    = (state_q == RUN);

`ifdef HIR_LOOP_CTRL_DELAY_EN
   hir_delay_line #(.DELAY(DELAY)) u_tloop_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (tloop_q),
      .dout  (tloop_dly)
   );

   hir_delay_line #(.DELAY(DELAY)) u_tfinish_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (tfinish_q),
      .dout  (tfinish_dly)
   );
`else
   logic unused_delay_cfg;
   assign unused_delay_cfg = (DELAY >= 1);
`endif

endmodule : hir_for_loop_ctrl

// File: tb/tb_hir_for_loop_ctrl.sv
// Directed bench for hir_for_loop_ctrl: a 32-bit instance for most cases and
// an 8-bit instance for the overflow-terminates case.
module tb_hir_for_loop_ctrl;

   localparam int DELAY = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        tstart = 1'b0;
   logic [31:0] lb = '0;
   logic [31:0] ub = '0;
   logic [7:0]  step = '0;
   logic        tloop_in = 1'b0;
   logic [31:0] idx;
   logic        tloop, tfinish, busy, err;

   logic        tstart8 = 1'b0;
   logic [7:0]  lb8 = '0;
   logic [7:0]  ub8 = '0;
   logic [7:0]  step8 = '0;
   logic        tloop_in8 = 1'b0;
   logic [7:0]  idx8;
   logic        tloop8, tfinish8, busy8, err8;

`ifdef HIR_LOOP_CTRL_DELAY_EN
   logic [DELAY-1:0] tloop_dly, tfinish_dly;
   logic [DELAY-1:0] tloop_dly8, tfinish_dly8;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hir_for_loop_ctrl #(.IDX_W(32), .STEP_W(8), .DELAY(DELAY)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tstart      (tstart),
      .lb          (lb),
      .ub          (ub),
      .step        (step),
      .tloop_in    (tloop_in),
      .idx         (idx),
      .tloop       (tloop),
      .tfinish     (tfinish),
      .busy        (busy),
      .err         (err)
`ifdef HIR_LOOP_CTRL_DELAY_EN
      ,
      .tloop_dly   (tloop_dly),
      .tfinish_dly (tfinish_dly)
`endif
   );

   hir_for_loop_ctrl #(.IDX_W(8), .STEP_W(8), .DELAY(DELAY)) dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .tstart      (tstart8),
      .lb          (lb8),
      .ub          (ub8),
      .step        (step8),
      .tloop_in    (tloop_in8),
      .idx         (idx8),
      .tloop       (tloop8),
      .tfinish     (tfinish8),
      .busy        (busy8),
      .err         (err8)
`ifdef HIR_LOOP_CTRL_DELAY_EN
      ,
      .tloop_dly   (tloop_dly8),
      .tfinish_dly (tfinish_dly8)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; outputs are stable there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start32(input logic [31:0] l, input logic [31:0] u, input logic [7:0] s);
      tstart = 1'b1; lb = l; ub = u; step = s;
      tick();
      tstart = 1'b0;
   endtask

   initial begin : main
      logic [DELAY-1:0] hist;
      int  tl_cnt;
      bit  seen;

      // Reset state
      #3;
      check("rst_idx", idx, 32'd0);
      check("rst_tloop", {31'd0, tloop}, 32'd0);
      check("rst_tfinish", {31'd0, tfinish}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: lb=0 ub=8 step=1, II=1
      start32(32'd0, 32'd8, 8'd1);
      for (int i = 0; i < 8; i++) begin
         check("t1_tloop", {31'd0, tloop}, 32'd1);
         check("t1_idx", idx, i);
         check("t1_busy", {31'd0, busy}, 32'd1);
         check("t1_err", {31'd0, err}, 32'd0);
         tloop_in = tloop;
         tick();
      end
      tloop_in = 1'b0;
      check("t1_tfinish", {31'd0, tfinish}, 32'd1);
      check("t1_tloop_end", {31'd0, tloop}, 32'd0);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      check("t1_err_end", {31'd0, err}, 32'd0);
      tick();
      check("t1_tfinish_pulse", {31'd0, tfinish}, 32'd0);

      // 2: lb=2 ub=9 step=3, yield 4 cycles after each tloop
      start32(32'd2, 32'd9, 8'd3);
      for (int i = 0; i < 3; i++) begin
         check("t2_tloop", {31'd0, tloop}, 32'd1);
         check("t2_idx", idx, 32'd2 + 32'd3 * i);
         for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_gap", {31'd0, tloop | tfinish}, 32'd0);
         end
         tloop_in = 1'b1;
         tick();
         tloop_in = 1'b0;
      end
      check("t2_tfinish", {31'd0, tfinish}, 32'd1);
      check("t2_idx_hold", idx, 32'd8);

      // 3: zero-trip, then refused zero step
      start32(32'd5, 32'd5, 8'd1);
      check("t3_tfinish", {31'd0, tfinish}, 32'd1);
      check("t3_tloop", {31'd0, tloop}, 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd0);
      check("t3_err", {31'd0, err}, 32'd0);
      start32(32'd0, 32'd4, 8'd0);
      check("t3z_tfinish", {31'd0, tfinish}, 32'd1);
      check("t3z_err", {31'd0, err}, 32'd1);
      check("t3z_busy", {31'd0, busy}, 32'd0);
      tick();
      check("t3z_err_pulse", {31'd0, err}, 32'd0);

      // 4: 8-bit index, 250 + 4 + 4 overflows and must terminate
      tstart8 = 1'b1; lb8 = 8'd250; ub8 = 8'd255; step8 = 8'd4;
      tick();
      tstart8 = 1'b0;
      check("t4_tloop0", {31'd0, tloop8}, 32'd1);
      check("t4_idx0", {24'd0, idx8}, 32'd250);
      tloop_in8 = 1'b1;
      tick();
      check("t4_tloop1", {31'd0, tloop8}, 32'd1);
      check("t4_idx1", {24'd0, idx8}, 32'd254);
      tick();
      tloop_in8 = 1'b0;
      check("t4_tfinish", {31'd0, tfinish8}, 32'd1);
      check("t4_no_wrap_tloop", {31'd0, tloop8}, 32'd0);
      check("t4_idx_hold", {24'd0, idx8}, 32'd254);
      check("t4_busy", {31'd0, busy8}, 32'd0);

      // 5: restart at idx=3, then stray yield in IDLE
      start32(32'd0, 32'd8, 8'd1);
      tloop_in = 1'b1;
      repeat (3) tick();
      check("t5_idx3", idx, 32'd3);
      tloop_in = 1'b0;
      start32(32'd10, 32'd12, 8'd1);
      check("t5_err", {31'd0, err}, 32'd1);
      check("t5_idx", idx, 32'd10);
      check("t5_tloop", {31'd0, tloop}, 32'd1);
      check("t5_no_tfinish", {31'd0, tfinish}, 32'd0);
      tloop_in = 1'b1;
      tick();
      check("t5_idx11", idx, 32'd11);
      check("t5_err_pulse", {31'd0, err}, 32'd0);
      tick();
      check("t5_tfinish", {31'd0, tfinish}, 32'd1);
      // tloop_in is still high here: a stray yield while IDLE
      tick();
      tloop_in = 1'b0;
      check("t5_stray_err", {31'd0, err}, 32'd1);
      check("t5_stray_tloop", {31'd0, tloop}, 32'd0);
      check("t5_stray_tfinish", {31'd0, tfinish}, 32'd0);
      check("t5_stray_idx", idx, 32'd11);
      check("t5_stray_busy", {31'd0, busy}, 32'd0);

      // 6: asynchronous reset at idx=4, then a full loop
      start32(32'd0, 32'd8, 8'd1);
      tloop_in = 1'b1;
      repeat (4) tick();
      tloop_in = 1'b0;
      check("t6_idx4", idx, 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_idx", idx, 32'd0);
      check("t6_rst_tloop", {31'd0, tloop}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_tfinish", {31'd0, tfinish}, 32'd0);
`ifdef HIR_LOOP_CTRL_DELAY_EN
      check("t6_rst_dly", {26'd0, tloop_dly}, 32'd0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      hist = '0;
      tstart = 1'b1; lb = 32'd0; ub = 32'd4; step = 8'd1;
      tick();
      tstart = 1'b0;
      hist = {hist[DELAY-2:0], tloop};
      seen = 1'b0;
      tl_cnt = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (tloop) begin
            check("t6_idx", idx, tl_cnt);
            tl_cnt++;
         end
`ifdef HIR_LOOP_CTRL_DELAY_EN
         check("t6_tloop_dly", {26'd0, tloop_dly}, {26'd0, hist});
`endif
         if (tfinish) begin
            seen = 1'b1;
         end else begin
            tloop_in = tloop;
            tick();
            hist = {hist[DELAY-2:0], tloop};
         end
      end
      tloop_in = 1'b0;
      check("t6_tfinish_seen", {31'd0, seen}, 32'd1);
      check("t6_tloop_count", tl_cnt, 32'd4);
`ifdef HIR_LOOP_CTRL_DELAY_EN
      // Keep clocking so tloop_dly[5] shows the last pulses five cycles later.
      for (int c = 0; c < DELAY; c++) begin
         tick();
         hist = {hist[DELAY-2:0], tloop};
         check("t6_tail_dly", {26'd0, tloop_dly}, {26'd0, hist});
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_hir_for_loop_ctrl
